// File: rtl/hsem_ahb_master_pkg.sv
// rtl/hsem_ahb_master_pkg.sv - AHB-Lite encodings and FSM states shared by the HSEM initiator
package hsem_ahb_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/hsem_ahb_mst_timeout.sv
// rtl/hsem_ahb_mst_timeout.sv - stall counter that aborts a transfer after TIMEOUT_CYCLES stalled cycles
module hsem_ahb_mst_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic hclk,
  input  logic hreset,
  input  logic busy,
  input  logic hready,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] stall_cnt;

  // Fires on the stalled cycle that would make the count reach the limit.
  assign timeout = busy && !hready && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      stall_cnt <= '0;
    end else if (!busy || hready || timeout) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hsem_ahb_master.sv
// rtl/hsem_ahb_master.sv - single-word AHB-Lite initiator for HSEM; optional stall timeout via HSEM_AHB_MST_TIMEOUT_EN
module hsem_ahb_master
  import hsem_ahb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [1:0]            htrans,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic                  hmastlock,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  input  logic                  hresp,
  input  logic [DATA_WIDTH-1:0] hrdata
);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  timeout;

  assign cmd_ready = (state == ST_IDLE);
  assign hsize     = HSIZE_WORD;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_DATA_PRIV;
  assign hmastlock = 1'b0;

`ifdef HSEM_AHB_MST_TIMEOUT_EN
  hsem_ahb_mst_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .hclk    (hclk),
    .hreset  (hreset),
    .busy    (state != ST_IDLE),
    .hready  (hready),
    .timeout (timeout)
  );
`else
  // Never true; keeps TIMEOUT_CYCLES referenced when the counter is absent.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= ST_IDLE;
      htrans    <= HTRANS_IDLE;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            htrans  <= HTRANS_NONSEQ;
            haddr   <= cmd_addr & ~ADDR_WIDTH'(3);
            hwrite  <= cmd_write;
            wdata_q <= cmd_wdata;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (timeout) begin
            htrans    <= HTRANS_IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= HRESP_ERROR;
            state     <= ST_IDLE;
          end else if (hready) begin
            htrans <= HTRANS_IDLE;
            // hwdata keeps the last written word across reads.
            if (hwrite) begin
              hwdata <= wdata_q;
            end
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (timeout) begin
            rsp_valid <= 1'b1;
            rsp_err   <= HRESP_ERROR;
            state     <= ST_IDLE;
          end else if (hready) begin
            rsp_valid <= 1'b1;
            rsp_err   <= hresp;
            if (!hwrite) begin
              rsp_rdata <= hrdata;
            end
            state <= ST_IDLE;
          end
        end
        default: begin
          htrans <= HTRANS_IDLE;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsem_ahb_master.sv
// tb/tb_hsem_ahb_master.sv - table-driven and randomized checks of hsem_ahb_master against a transaction model
module tb_hsem_ahb_master;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hmastlock, hready, hresp;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_rdata;
  logic [31:0] m_wdata;

  always #5 hclk = ~hclk;

  hsem_ahb_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the response cycle.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int aw, input int dw, input logic err, input logic [31:0] rd,
                        output int lat, output logic g_err, output logic [31:0] g_rd);
    int cyc;
    logic [31:0] exp_addr;
    exp_addr = addr & 32'hFFFF_FFFC;
    lat = -1; g_err = 1'b0; g_rd = '0; cyc = 0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    hready = 1'b1; hresp = 1'b0;
    @(negedge hclk); cyc++;
    chk("rsp_valid_single_pulse", rsp_valid, 0);
    for (int i = 0; i <= aw; i++) begin
      if (i > 0) begin @(negedge hclk); cyc++; end
      chk("htrans_nonseq", htrans, 2'b10);
      chk("haddr", haddr, exp_addr);
      chk("hwrite", hwrite, wr);
      chk("cmd_ready_busy_addr", cmd_ready, 0);
      cmd_valid = 1'($urandom_range(0, 1)); cmd_write = ~wr;
      cmd_addr = $urandom; cmd_wdata = $urandom;
      hready = (i == aw); hresp = 1'b0;
    end
    if (wr) m_wdata = wd;
    for (int i = 0; i <= dw; i++) begin
      @(negedge hclk); cyc++;
      chk("htrans_idle_data", htrans, 2'b00);
      chk("hwdata", hwdata, m_wdata);
      chk("cmd_ready_busy_data", cmd_ready, 0);
      chk("rsp_valid_early", rsp_valid, 0);
      hready = (i == dw);
      hresp  = err && (i >= dw - 1);
      hrdata = (i == dw) ? rd : $urandom;
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge hclk); cyc++;
      hready = 1'b1; hresp = 1'b0;
      if (rsp_valid) begin
        lat = cyc; g_err = rsp_err; g_rd = rsp_rdata;
        chk("cmd_ready_after_rsp", cmd_ready, 1);
        chk("htrans_after_rsp", htrans, 2'b00);
        break;
      end
    end
    chk("rsp_seen", rsp_valid, 1);
  endtask

  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wd; int aw; int dw; logic err; logic [31:0] rd;
    int exp_lat; logic exp_err; logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    logic g_err;
    logic [31:0] g_rd;
    logic wr, err;
    int aw, dw;
    logic [31:0] rd, exp_rd;
    int cyc;
    bit seen;

    vecs[0] = '{1'b1, 32'h0000_0004, 32'hA5A5_0001, 0, 0, 1'b0, 32'h0,         3, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         0, 2, 1'b0, 32'h3,         5, 1'b0, 32'h3};
    vecs[2] = '{1'b1, 32'h0000_0013, 32'h5A5A_0002, 3, 0, 1'b0, 32'h0,         6, 1'b0, 32'h3};
    vecs[3] = '{1'b0, 32'h0000_0020, 32'h0,         0, 1, 1'b1, 32'hDEAD_BEEF, 4, 1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 32'h0000_0024, 32'h1111_2222, 1, 1, 1'b1, 32'h0,         5, 1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         2, 3, 1'b0, 32'h1234_5678, 8, 1'b0, 32'h1234_5678};

    hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    m_rdata = '0; m_wdata = '0;
    repeat (2) @(negedge hclk);
    chk("reset_htrans", htrans, 2'b00);
    chk("reset_haddr", haddr, 0);
    chk("reset_hwrite", hwrite, 0);
    chk("reset_hwdata", hwdata, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("const_hsize", hsize, 3'b010);
    chk("const_hburst", hburst, 3'b000);
    chk("const_hprot", hprot, 4'b0011);
    chk("const_hmastlock", hmastlock, 0);
    hreset = 1'b0;
    @(negedge hclk);

    foreach (vecs[k]) begin
      do_txn(vecs[k].wr, vecs[k].addr, vecs[k].wd, vecs[k].aw, vecs[k].dw, vecs[k].err,
             vecs[k].rd, lat, g_err, g_rd);
      chk($sformatf("vec%0d_latency", k), lat, vecs[k].exp_lat);
      chk($sformatf("vec%0d_rsp_err", k), g_err, vecs[k].exp_err);
      chk($sformatf("vec%0d_rsp_rdata", k), g_rd, vecs[k].exp_rdata);
      if (!vecs[k].wr) m_rdata = vecs[k].rd;
    end

    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      err = ($urandom_range(0, 3) == 0);
      aw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      if (err && dw == 0) dw = 1;
      rd = $urandom;
      exp_rd = wr ? m_rdata : rd;
      do_txn(wr, $urandom, $urandom, aw, dw, err, rd, lat, g_err, g_rd);
      chk("rand_latency", lat, 3 + aw + dw);
      chk("rand_rsp_err", g_err, err);
      chk("rand_rsp_rdata", g_rd, exp_rd);
      m_rdata = exp_rd;
    end

    // Reset asserted mid data phase aborts without a response.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'hCAFE_F00D;
    hready = 1'b1;
    @(negedge hclk);
    cmd_valid = 1'b0;
    @(negedge hclk);
    chk("pre_reset_hwdata", hwdata, 32'hCAFE_F00D);
    hready = 1'b0;
    #2 hreset = 1'b1;
    #1;
    chk("abort_htrans", htrans, 2'b00);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_hwdata", hwdata, 0);
    chk("abort_rsp_rdata", rsp_rdata, 0);
    @(negedge hclk);
    hreset = 1'b0; hready = 1'b1;
    m_rdata = '0; m_wdata = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge hclk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    do_txn(1'b0, 32'h0000_000C, 32'h0, 0, 0, 1'b0, 32'h0000_0077, lat, g_err, g_rd);
    chk("post_reset_latency", lat, 3);
    chk("post_reset_rsp_err", g_err, 0);
    chk("post_reset_rdata", g_rd, 32'h0000_0077);
    m_rdata = 32'h0000_0077;

`ifdef HSEM_AHB_MST_TIMEOUT_EN
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; hready = 1'b1;
    @(negedge hclk);
    cmd_valid = 1'b0; hready = 1'b0; cyc = 1; seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge hclk); cyc++;
      if (rsp_valid) begin
        seen = 1;
        chk("timeout_latency", cyc, 9);
        chk("timeout_rsp_err", rsp_err, 1);
        chk("timeout_rsp_rdata", rsp_rdata, m_rdata);
        chk("timeout_cmd_ready", cmd_ready, 1);
        chk("timeout_htrans", htrans, 2'b00);
        break;
      end
    end
    chk("timeout_seen", seen, 1);
    hready = 1'b1;
`else
    seen = 0; cyc = 0;
`endif

    @(negedge hclk);
    chk("final_rsp_valid_low", rsp_valid, 0);
    chk("final_cmd_ready", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
